uart_rx_cfg: RTL and testbench

UART_RX_CFG -- requirements
Module: uart_rx_cfg

---
 rtl/uart_rx_cfg.sv | 183 ++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop synchroniser, mid-bit sampling FSM, valid/ready output hold with overrun.
// Define UART_RX_MAJORITY_EN to take each bit sample as a 2-of-3 vote around the sample clock.
module uart_rx_cfg #(
    parameter int CLK_RATE      = 100_000_000,
    parameter int BAUD_RATE     = 115200,
    parameter int NCLKS_PER_BIT = CLK_RATE / BAUD_RATE,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_overrun,
    output logic                 o_busy
);

    localparam int CNT_W = $clog2(NCLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_TC   = CNT_W'(NCLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_TC   = CNT_W'(NCLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = (STOP_BITS == 2);
    localparam logic             ODD_PAR   = (PARITY == 2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_acc_q, par_acc_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 rx_meta_q, rx_sync_q, rx_prev_q;
    logic                 rx_bit;
    logic                 done;

    // rx_prev_q doubles as the edge-detect history and the "-1" tap of the vote.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= i_rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // The "+1" tap is the sample one flop upstream, so the vote adds no latency.
    assign rx_bit = (rx_prev_q & rx_sync_q) | (rx_prev_q & rx_meta_q) | (rx_sync_q & rx_meta_q);
`else
    assign rx_bit = rx_sync_q;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_d     = bit_q;
        stop_d    = stop_q;
        shift_d   = shift_q;
        par_acc_d = par_acc_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        done      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) begin
                    state_d   = ST_START;
                    bit_d     = '0;
                    stop_d    = 1'b0;
                    par_acc_d = 1'b0;
                    perr_d    = 1'b0;
                    ferr_d    = 1'b0;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_TC) begin
                    cnt_d   = '0;
                    state_d = rx_bit ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt_q == FULL_TC) begin
                    cnt_d     = '0;
                    shift_d   = {rx_bit, shift_q[DATA_BITS-1:1]};
                    par_acc_d = par_acc_q ^ rx_bit;
                    bit_d     = bit_q + 1'b1;
                    if (bit_q == LAST_BIT) begin
                        state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (cnt_q == FULL_TC) begin
                    cnt_d   = '0;
                    perr_d  = ((par_acc_q ^ rx_bit) != ODD_PAR);
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (cnt_q == FULL_TC) begin
                    cnt_d = '0;
                    if (!rx_bit) begin
                        ferr_d = 1'b1;
                    end
                    if (stop_q == LAST_STOP) begin
                        state_d = ST_IDLE;
                        done    = 1'b1;
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q   <= shift_d;
        par_acc_q <= par_acc_d;
        perr_q    <= perr_d;
        ferr_q    <= ferr_d;
    end

    // A finished frame loads only if the slot is empty or being handed off this very edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_overrun    <= 1'b0;
        end else if (done && (!o_valid || i_ready)) begin
            o_data       <= shift_q;
            o_valid      <= 1'b1;
            o_parity_err <= perr_q;
            o_frame_err  <= ferr_d;
            o_overrun    <= 1'b0;
        end else if (done) begin
            o_overrun <= 1'b1;
        end else if (o_valid && i_ready) begin
            o_valid   <= 1'b0;
            o_overrun <= 1'b0;
        end
    end

    assign o_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg at 16 clocks per bit: an 8N1 instance and an 8E1 instance.
module tb_uart_rx_cfg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, rx, rx_p, rdy, rdy_p;
    logic [7:0] o_data, o_data_p;
    logic       o_valid, o_perr, o_ferr, o_ovr, o_busy;
    logic       o_valid_p, o_perr_p, o_ferr_p, o_ovr_p, o_busy_p;

    uart_rx_cfg #(.NCLKS_PER_BIT(16)) dut (
        .clk(clk), .rst(rst), .i_rx(rx), .o_data(o_data), .o_valid(o_valid), .i_ready(rdy),
        .o_parity_err(o_perr), .o_frame_err(o_ferr), .o_overrun(o_ovr), .o_busy(o_busy)
    );

    uart_rx_cfg #(.NCLKS_PER_BIT(16), .PARITY(1)) dut_p (
        .clk(clk), .rst(rst), .i_rx(rx_p), .o_data(o_data_p), .o_valid(o_valid_p), .i_ready(rdy_p),
        .o_parity_err(o_perr_p), .o_frame_err(o_ferr_p), .o_overrun(o_ovr_p), .o_busy(o_busy_p)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   vcnt     = 0;
    int   vcnt_p   = 0;
    int   busy_cnt = 0;
    logic vprev    = 1'b0;
    logic vprev_p  = 1'b0;

    always @(posedge clk) begin
        if (o_valid === 1'b1 && vprev !== 1'b1) vcnt <= vcnt + 1;
        if (o_valid_p === 1'b1 && vprev_p !== 1'b1) vcnt_p <= vcnt_p + 1;
        if (o_busy === 1'b1) busy_cnt <= busy_cnt + 1;
        vprev   <= o_valid;
        vprev_p <= o_valid_p;
    end

    task automatic set_line(input bit sel, input logic v);
        if (sel) rx_p = v;
        else     rx   = v;
    endtask

    // 16 negedges per bit; an optional 1-clock inversion lands on the mid-bit sample clock.
    task automatic drive_bit(input bit sel, input logic b, input bit glitch);
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            set_line(sel, (glitch && j == 8) ? ~b : b);
        end
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d, input int par, input logic stp, input int gbit);
        drive_bit(sel, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(sel, d[i], (i == gbit));
        if (par >= 0) drive_bit(sel, par[0], 1'b0);
        drive_bit(sel, stp, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; rx = 1'b1; rx_p = 1'b1; rdy = 1'b1; rdy_p = 1'b1;
        idle(4);
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", o_valid); end
        n_checks++; if (o_data !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %h want 00", o_data); end
        n_checks++; if ({o_perr, o_ferr, o_ovr, o_busy} !== 4'b0) begin n_fail++; $display("FAIL rst_flags: got %b want 0000", {o_perr, o_ferr, o_ovr, o_busy}); end
        n_checks++; if ({o_valid_p, o_perr_p, o_ferr_p, o_ovr_p, o_busy_p} !== 5'b0) begin n_fail++; $display("FAIL rst_par_dut: got %b want 00000", {o_valid_p, o_perr_p, o_ferr_p, o_ovr_p, o_busy_p}); end
        rst = 1'b0;
        idle(20);
        n_checks++; if (vcnt !== 0 || o_busy !== 1'b0) begin n_fail++; $display("FAIL rst_no_false_start: vcnt %0d busy %b want 0 0", vcnt, o_busy); end
    endtask

    task automatic test_basic;
        int v0;
        v0 = vcnt;
        send_frame(1'b0, 8'hA5, -1, 1'b1, -1);
        idle(20);
        n_checks++; if (vcnt - v0 !== 1) begin n_fail++; $display("FAIL a5_pulses: got %0d want 1", vcnt - v0); end
        n_checks++; if (o_data !== 8'hA5) begin n_fail++; $display("FAIL a5_data: got %h want a5", o_data); end
        n_checks++; if ({o_perr, o_ferr, o_ovr, o_valid} !== 4'b0) begin n_fail++; $display("FAIL a5_flags: got %b want 0000", {o_perr, o_ferr, o_ovr, o_valid}); end
    endtask

    task automatic test_parity;
        send_frame(1'b1, 8'h03, 1, 1'b1, -1);
        idle(20);
        n_checks++; if (o_data_p !== 8'h03) begin n_fail++; $display("FAIL par1_data: got %h want 03", o_data_p); end
        n_checks++; if (o_perr_p !== 1'b1) begin n_fail++; $display("FAIL par1_err: got %b want 1", o_perr_p); end
        send_frame(1'b1, 8'h03, 0, 1'b1, -1);
        idle(20);
        n_checks++; if (o_data_p !== 8'h03 || o_perr_p !== 1'b0 || o_ferr_p !== 1'b0) begin n_fail++; $display("FAIL par0: data %h perr %b ferr %b want 03 0 0", o_data_p, o_perr_p, o_ferr_p); end
        n_checks++; if (vcnt_p !== 2) begin n_fail++; $display("FAIL par_pulses: got %0d want 2", vcnt_p); end
    endtask

    task automatic test_frame_err;
        int v0;
        v0 = vcnt;
        send_frame(1'b0, 8'h55, -1, 1'b0, -1);
        idle(48);
        n_checks++; if (vcnt - v0 !== 1 || o_data !== 8'h55 || o_ferr !== 1'b1) begin n_fail++; $display("FAIL ferr_word: n %0d data %h ferr %b want 1 55 1", vcnt - v0, o_data, o_ferr); end
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL ferr_low_retrigger: busy %b want 0", o_busy); end
        rx = 1'b1;
        idle(32);
        n_checks++; if (vcnt - v0 !== 1) begin n_fail++; $display("FAIL ferr_quiet: got %0d want 1", vcnt - v0); end
        send_frame(1'b0, 8'h96, -1, 1'b1, -1);
        idle(20);
        n_checks++; if (vcnt - v0 !== 2 || o_data !== 8'h96 || o_ferr !== 1'b0) begin n_fail++; $display("FAIL ferr_recover: n %0d data %h ferr %b want 2 96 0", vcnt - v0, o_data, o_ferr); end
    endtask

    task automatic test_break;
        int v0;
        v0 = vcnt;
        @(negedge clk); rx = 1'b0;
        idle(16 * 12);
        n_checks++; if (vcnt - v0 !== 1 || o_data !== 8'h00 || o_ferr !== 1'b1) begin n_fail++; $display("FAIL break_word: n %0d data %h ferr %b want 1 00 1", vcnt - v0, o_data, o_ferr); end
        rx = 1'b1;
        idle(32);
        n_checks++; if (vcnt - v0 !== 1) begin n_fail++; $display("FAIL break_quiet: got %0d want 1", vcnt - v0); end
    endtask

    task automatic test_overrun;
        rdy = 1'b0;
        send_frame(1'b0, 8'h11, -1, 1'b1, -1);
        idle(4);
        n_checks++; if (o_valid !== 1'b1 || o_ovr !== 1'b0) begin n_fail++; $display("FAIL ovr_first: valid %b ovr %b want 1 0", o_valid, o_ovr); end
        send_frame(1'b0, 8'h22, -1, 1'b1, -1);
        idle(4);
        n_checks++; if (o_data !== 8'h11 || o_ovr !== 1'b1 || o_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_hold: data %h ovr %b valid %b want 11 1 1", o_data, o_ovr, o_valid); end
        rdy = 1'b1;
        @(negedge clk);
        n_checks++; if (o_valid !== 1'b0 || o_ovr !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: valid %b ovr %b want 0 0", o_valid, o_ovr); end
        idle(16);
    endtask

    task automatic test_back_to_back;
        rdy = 1'b0;
        send_frame(1'b0, 8'h11, -1, 1'b1, -1);
        fork
            send_frame(1'b0, 8'h22, -1, 1'b1, -1);
            begin
                @(negedge clk);
                repeat (154) @(negedge clk);
                rdy = 1'b1;
                @(negedge clk);
                rdy = 1'b0;
            end
        join
        n_checks++; if (o_data !== 8'h22 || o_valid !== 1'b1 || o_ovr !== 1'b0) begin n_fail++; $display("FAIL b2b_load: data %h valid %b ovr %b want 22 1 0", o_data, o_valid, o_ovr); end
        rdy = 1'b1;
        @(negedge clk);
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: valid %b want 0", o_valid); end
        idle(16);
    endtask

    task automatic test_glitch;
        int v0, b0;
        v0 = vcnt; b0 = busy_cnt;
        @(negedge clk); rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(32);
        n_checks++; if (busy_cnt - b0 !== 8) begin n_fail++; $display("FAIL glitch_busy: got %0d cycles want 8", busy_cnt - b0); end
        n_checks++; if (vcnt - v0 !== 0 || o_busy !== 1'b0) begin n_fail++; $display("FAIL glitch_quiet: n %0d busy %b want 0 0", vcnt - v0, o_busy); end
        send_frame(1'b0, 8'h3C, -1, 1'b1, -1);
        idle(20);
        n_checks++; if (vcnt - v0 !== 1 || o_data !== 8'h3C) begin n_fail++; $display("FAIL glitch_then_3c: n %0d data %h want 1 3c", vcnt - v0, o_data); end
    endtask

    task automatic test_majority;
        logic [7:0] exp_d;
`ifdef UART_RX_MAJORITY_EN
        exp_d = 8'h00;
`else
        exp_d = 8'h08;
`endif
        send_frame(1'b0, 8'h00, -1, 1'b1, 3);
        idle(20);
        n_checks++; if (o_data !== exp_d) begin n_fail++; $display("FAIL mid_glitch_data: got %h want %h", o_data, exp_d); end
    endtask

    task automatic test_reset_midframe;
        int v0;
        rdy = 1'b0;
        send_frame(1'b0, 8'h5A, -1, 1'b1, -1);
        idle(4);
        v0 = vcnt;
        @(negedge clk); rx = 1'b0;
        idle(40);
        n_checks++; if (o_busy !== 1'b1 || o_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre: busy %b valid %b want 1 1", o_busy, o_valid); end
        rx = 1'b1; rst = 1'b1;
        idle(2);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (o_valid !== 1'b0 || o_data !== 8'h00 || o_busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst: valid %b data %h busy %b want 0 00 0", o_valid, o_data, o_busy); end
        idle(200);
        n_checks++; if (vcnt !== v0 || o_busy !== 1'b0) begin n_fail++; $display("FAIL mid_discard: n %0d busy %b want %0d 0", vcnt, o_busy, v0); end
        rdy = 1'b1;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_parity;
        test_frame_err;
        test_break;
        test_overrun;
        test_back_to_back;
        test_glitch;
        test_majority;
        test_reset_midframe;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
